// File: rtl/aes_pkg.sv
// AES-128 shared definitions: round count, word/block types, key-expander
// FSM states, the forward S-box table and the key-schedule round constants.
// Used by the key expander and by the data-path S-box.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_READY
  } kexp_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant for round key r (1..10); 0 elsewhere.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word. Purely combinational.
// Ports:
//   in_word  - input word
//   out_word - byte-wise S-box substitution of in_word
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t in_word,
  output word_t out_word
);

  assign out_word = {sbox(in_word[31:24]), sbox(in_word[23:16]),
                     sbox(in_word[15:8]),  sbox(in_word[7:0])};

endmodule

// File: rtl/aes_key_expander.sv
// AES-128 key expander. Expands cipher_key into round keys 0..NUM_ROUNDS,
// one per clock, into an internal key memory, and serves the key selected
// by round_idx.
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset
//   key_load   - one-cycle strobe: latch cipher_key and (re)start expansion
//   cipher_key - AES key, w0 = bits[127:96]
//   round_idx  - round key select (11..15 read as zero)
//   round_key  - selected round key
//   key_ready  - all round keys valid
//   busy       - expansion in progress
// Build option: define AES_KEYEXP_OUT_REG_EN to register round_key
// (one-cycle read latency); default is a combinational read.
//
// state     | meaning
// ----------+--------------------------------
// ST_IDLE   | no key expanded yet
// ST_EXPAND | writing round keys 1..NUM_ROUNDS
// ST_READY  | all round keys valid
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_load,
  input  logic [127:0] cipher_key,
  input  logic [3:0]   round_idx,
  output logic [127:0] round_key,
  output logic         key_ready,
  output logic         busy
);

  kexp_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  block_t      mem_q [NUM_ROUNDS+1];
  block_t      mem_d [NUM_ROUNDS+1];

  block_t prev_key;
  word_t  sub_in, sub_out, t_word;
  word_t  w0_n, w1_n, w2_n, w3_n;
  block_t rd_data;

  // cnt_q is never 0 in ST_EXPAND; the guard only keeps the index in range.
  assign prev_key = (cnt_q != 4'd0) ? mem_q[cnt_q - 4'd1] : '0;
  assign sub_in   = {prev_key[23:0], prev_key[31:24]};

  aes_sub_word u_sub_word (
    .in_word  (sub_in),
    .out_word (sub_out)
  );

  assign t_word = sub_out ^ {rcon(cnt_q), 24'h0};
  assign w0_n   = prev_key[127:96] ^ t_word;
  assign w1_n   = prev_key[95:64]  ^ w0_n;
  assign w2_n   = prev_key[63:32]  ^ w1_n;
  assign w3_n   = prev_key[31:0]   ^ w2_n;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    if (key_load) begin
      // Load wins in every state, so a load mid-expansion simply restarts.
      mem_d[0] = cipher_key;
      cnt_d    = 4'd1;
      state_d  = ST_EXPAND;
    end else if (state_q == ST_EXPAND) begin
      mem_d[cnt_q] = {w0_n, w1_n, w2_n, w3_n};
      if (cnt_q == 4'(NUM_ROUNDS)) begin
        state_d = ST_READY;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  // Both flags decode the state register, so they can never be high together.
  assign key_ready = (state_q == ST_READY);
  assign busy      = (state_q == ST_EXPAND);

  assign rd_data = (round_idx <= 4'(NUM_ROUNDS)) ? mem_q[round_idx] : '0;

`ifdef AES_KEYEXP_OUT_REG_EN
  block_t round_key_q, round_key_d;

  always_comb begin
    round_key_d = rd_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      round_key_q <= '0;
    end else begin
      round_key_q <= round_key_d;
    end
  end

  assign round_key = round_key_q;
`else
  assign round_key = rd_data;
`endif

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Upstream neighbour of the AES-128 round-processing core.
- Expands a 128-bit cipher key into the 11 round keys (round 0..10), one round key per clock, into an internal key memory.
- Serves the round key selected by the core's 4-bit round count.
- Lets the processing core run back-to-back blocks under one key without re-expansion.

Parameters:
- NUM_ROUNDS, 10, last round index; round keys 0..NUM_ROUNDS are stored. Fixed at 10 for AES-128; other values are unsupported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- key_load  in  1  one-cycle strobe; latches cipher_key and starts expansion
- cipher_key  in  128  AES key; byte 0 = bits[127:120]; word w0 = bits[127:96]
- round_idx  in  4  round key select, driven by the core's round counter
- round_key  out  128  round key for round_idx
- key_ready  out  1  high when all 11 round keys are valid
- busy  out  1  high while expansion is in progress

Behaviour:
- Reset (reset=0, async): state=IDLE, cnt=0, all key memory entries=0, key_ready=0, busy=0, round_key=0.
- FSM states:
  - IDLE: no key expanded yet.
  - EXPAND: expansion in progress.
  - READY: all round keys valid.
- key_load=1 at a posedge, in any state:
  - mem[0] <= cipher_key, cnt <= 1, state <= EXPAND.
  - key_ready <= 0, busy <= 1.
- EXPAND, each cycle:
  - mem[cnt] <= next_key(mem[cnt-1], rcon[cnt]); cnt <= cnt+1.
  - On the cycle that writes mem[10]: state <= READY, key_ready <= 1, busy <= 0, cnt <= 0.
- Latency: key_ready rises exactly 10 clocks after the key_load edge. Round keys become readable in order as they are written.
- next_key:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 (constant table).
- round_key = mem[round_idx] combinationally when round_idx <= 10. round_idx in 11..15 gives all zeros.
- Reads during EXPAND are allowed. Entries not yet written in the current expansion hold stale data; the consumer must wait for key_ready.
- key_load during EXPAND: abort, restart with the new key. No merge.
- key_load in READY: key_ready drops on the next edge; new expansion begins.
- Asserting reset mid-expansion clears everything; no partial key survives.
- key_load while reset=0 is ignored.
- busy and key_ready are never both 1.

Optional Feature:
- Macro: AES_KEYEXP_OUT_REG_EN.
- Defined:
  - round_key is registered: a round_idx presented before an edge yields round_key after that edge (1-cycle read latency).
  - The registered output resets to 0.
  - An out-of-range round_idx registers 0.
- Undefined: combinational read, zero latency, as described above.
- The processing core must be built for the matching latency.

Decomposition:
- Shared package aes_pkg: AES_NR=10, the RCON table (function or 10-entry constant array), the word_t (32-bit) and block_t (128-bit) typedefs, and the S-box function/table shared with the data-path S-box.
- One sub-module, aes_sub_word: 4 parallel S-box lookups on a 32-bit word. Combinational, instantiated once for the SubWord step.

Test Plan:
- FIPS-197 key: key_load with 2b7e151628aed2a6abf7158809cf4f3c.
  - key_ready=1 exactly 10 clocks later.
  - round_idx=0 gives 2b7e151628aed2a6abf7158809cf4f3c.
  - round_idx=1 gives a0fafe1788542cb123a339392a6c7605.
  - round_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key:
  - round 1 = 62636363626363636263636362636363.
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
  - round_idx=12 gives 0.
- Restart mid-expansion: load the zero key, then load the FIPS key 4 cycles later.
  - key_ready appears 10 clocks after the second load.
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Reset mid-expansion: assert reset=0 at cycle 5 of expansion.
  - key_ready=0, busy=0, round_key=0 for all idx, asynchronously, without waiting for a clock edge.
  - After release, a reload completes normally.
- Reload in READY: FIPS key READY, then load the zero key.
  - key_ready falls on the next edge and rises again 10 clocks after the load.
  - round 1 = 62636363626363636263636362636363.
- AES_KEYEXP_OUT_REG_EN defined, FIPS key loaded:
  - Step round_idx 0..10, one per cycle; each round_key appears one cycle after its idx.
  - Value at idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
